// File: rtl/osc_voice_scheduler_pkg.sv
// Shared types and the phase-to-saw helper for the oscillator voice scheduler.
// Pure declarations; no latency, no flow control.
package osc_voice_scheduler_pkg;

    typedef enum logic [1:0] {IDLE_E, CALC_E, EMIT_E} state_t;

    // Wide enough for any phase width a caller is likely to instantiate.
    localparam int PHASE_MAX_C = 64;

    // Top saw_w bits of the phase with the MSB inverted: an unsigned ramp becomes a
    // two's-complement ramp centred on zero. Caller truncates to saw_w bits.
    function automatic logic [PHASE_MAX_C-1:0] saw_from_phase(
        input logic [PHASE_MAX_C-1:0] phase,
        input int                     phase_w,
        input int                     saw_w
    );
        logic [PHASE_MAX_C-1:0] msbs;
        msbs = phase >> (phase_w - saw_w);
        return msbs ^ (PHASE_MAX_C'(1) << (saw_w - 1));
    endfunction

endpackage

// File: rtl/osc_voice_bank.sv
// Per-voice increment/enable/phase storage: one config write port, one phase RMW port.
// Reads are combinational; writes land on the next clk edge; no backpressure.
// Out-of-range voice indices read as zero and are dropped on write.
module osc_voice_bank
    import osc_voice_scheduler_pkg::*;
#(
    parameter int NR_OF_VOICES_P = 4,
    parameter int VOICE_WIDTH_P  = $clog2(NR_OF_VOICES_P),
    parameter int PHASE_WIDTH_P  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_wr,
    input  logic [VOICE_WIDTH_P-1:0] cfg_voice,
    input  logic [PHASE_WIDTH_P-1:0] cfg_increment,
    input  logic                     cfg_enable,
    input  logic [VOICE_WIDTH_P-1:0] rmw_voice,
    output logic [PHASE_WIDTH_P-1:0] rmw_phase,
    output logic [PHASE_WIDTH_P-1:0] rmw_increment,
    output logic                     rmw_enable,
    input  logic                     rmw_wr,
    input  logic [PHASE_WIDTH_P-1:0] rmw_phase_new
);

    logic [PHASE_WIDTH_P-1:0]  increment_q [NR_OF_VOICES_P];
    logic [PHASE_WIDTH_P-1:0]  increment_d [NR_OF_VOICES_P];
    logic [PHASE_WIDTH_P-1:0]  phase_q     [NR_OF_VOICES_P];
    logic [PHASE_WIDTH_P-1:0]  phase_d     [NR_OF_VOICES_P];
    logic [NR_OF_VOICES_P-1:0] enable_q;
    logic [NR_OF_VOICES_P-1:0] enable_d;

    logic cfg_hit;
    logic rmw_hit;

    assign cfg_hit = int'(cfg_voice) < NR_OF_VOICES_P;
    assign rmw_hit = int'(rmw_voice) < NR_OF_VOICES_P;

    assign rmw_phase     = rmw_hit ? phase_q[rmw_voice]     : '0;
    assign rmw_increment = rmw_hit ? increment_q[rmw_voice] : '0;
    assign rmw_enable    = rmw_hit ? enable_q[rmw_voice]    : 1'b0;

    always_comb begin
        increment_d = increment_q;
        enable_d    = enable_q;
        phase_d     = phase_q;
        if (cfg_wr && cfg_hit) begin
            increment_d[cfg_voice] = cfg_increment;
            enable_d[cfg_voice]    = cfg_enable;
        end
        if (rmw_wr && rmw_hit) begin
            phase_d[rmw_voice] = rmw_phase_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            increment_q <= '{default: '0};
            phase_q     <= '{default: '0};
            enable_q    <= '0;
        end else begin
            increment_q <= increment_d;
            phase_q     <= phase_d;
            enable_q    <= enable_d;
        end
    end

endmodule

// File: rtl/osc_voice_scheduler.sv
// Time-multiplexes one sawtooth phase accumulator across all voices, one frame per smp_tick.
// Latency: tick sampled at edge t gives voice 0 valid after edge t+1; 2 cycles per voice.
// Backpressure: osc_valid/voice/saw hold while !osc_ready; ticks arriving mid-frame are dropped.
module osc_voice_scheduler
    import osc_voice_scheduler_pkg::*;
#(
    parameter int NR_OF_VOICES_P = 4,
    parameter int VOICE_WIDTH_P  = $clog2(NR_OF_VOICES_P),
    parameter int PHASE_WIDTH_P  = 24,
    parameter int SAW_WIDTH_P    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     smp_tick,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [VOICE_WIDTH_P-1:0] cfg_voice,
    input  logic [PHASE_WIDTH_P-1:0] cfg_increment,
    input  logic                     cfg_enable,
    output logic                     osc_valid,
    input  logic                     osc_ready,
    output logic [VOICE_WIDTH_P-1:0] osc_voice,
    output logic [SAW_WIDTH_P-1:0]   osc_saw,
    output logic                     busy,
    output logic                     sample_overrun
);

    state_t                   state_q, state_d;
    logic [VOICE_WIDTH_P-1:0] voice_q, voice_d;
    logic                     osc_valid_q, osc_valid_d;
    logic [VOICE_WIDTH_P-1:0] osc_voice_q, osc_voice_d;
    logic [SAW_WIDTH_P-1:0]   osc_saw_q, osc_saw_d;
    logic                     sample_overrun_q, sample_overrun_d;

    logic [PHASE_WIDTH_P-1:0] rd_phase;
    logic [PHASE_WIDTH_P-1:0] rd_increment;
    logic                     rd_enable;
    logic                     phase_wr;
    logic [PHASE_WIDTH_P-1:0] phase_new;

    // The tick term keeps a config write from racing the first phase read of a new frame.
    assign cfg_ready      = (state_q == IDLE_E) && !smp_tick;
    assign busy           = (state_q != IDLE_E);
    assign osc_valid      = osc_valid_q;
    assign osc_voice      = osc_voice_q;
    assign osc_saw        = osc_saw_q;
    assign sample_overrun = sample_overrun_q;

    osc_voice_bank #(
        .NR_OF_VOICES_P (NR_OF_VOICES_P),
        .VOICE_WIDTH_P  (VOICE_WIDTH_P),
        .PHASE_WIDTH_P  (PHASE_WIDTH_P)
    ) u_bank (
        .clk           (clk),
        .rst           (rst),
        .cfg_wr        (cfg_valid && cfg_ready),
        .cfg_voice     (cfg_voice),
        .cfg_increment (cfg_increment),
        .cfg_enable    (cfg_enable),
        .rmw_voice     (voice_q),
        .rmw_phase     (rd_phase),
        .rmw_increment (rd_increment),
        .rmw_enable    (rd_enable),
        .rmw_wr        (phase_wr),
        .rmw_phase_new (phase_new)
    );

    always_comb begin
        state_d          = state_q;
        voice_d          = voice_q;
        osc_valid_d      = osc_valid_q;
        osc_voice_d      = osc_voice_q;
        osc_saw_d        = osc_saw_q;
        phase_wr         = 1'b0;
        phase_new        = '0;
        sample_overrun_d = smp_tick && (state_q != IDLE_E);

        case (state_q)
            IDLE_E: begin
                if (smp_tick) begin
                    state_d = CALC_E;
                    voice_d = '0;
                end
            end
            CALC_E: begin
                // Disabled voices are parked at phase zero so re-enabling restarts cleanly.
                if (rd_enable) begin
                    phase_new = rd_phase + rd_increment;
                    osc_saw_d = SAW_WIDTH_P'(saw_from_phase(PHASE_MAX_C'(phase_new),
                                                            PHASE_WIDTH_P, SAW_WIDTH_P));
                end else begin
                    osc_saw_d = '0;
                end
                phase_wr    = 1'b1;
                osc_voice_d = voice_q;
                osc_valid_d = 1'b1;
                state_d     = EMIT_E;
            end
            EMIT_E: begin
                if (osc_ready) begin
                    osc_valid_d = 1'b0;
                    if (voice_q == VOICE_WIDTH_P'(NR_OF_VOICES_P - 1)) begin
                        state_d = IDLE_E;
                    end else begin
                        voice_d = voice_q + 1'b1;
                        state_d = CALC_E;
                    end
                end
            end
            default: state_d = IDLE_E;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE_E;
            voice_q          <= '0;
            osc_valid_q      <= 1'b0;
            osc_voice_q      <= '0;
            osc_saw_q        <= '0;
            sample_overrun_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            voice_q          <= voice_d;
            osc_valid_q      <= osc_valid_d;
            osc_voice_q      <= osc_voice_d;
            osc_saw_q        <= osc_saw_d;
            sample_overrun_q <= sample_overrun_d;
        end
    end

endmodule

// File: tb/tb_osc_voice_scheduler.sv
// Scoreboard bench for osc_voice_scheduler: a behavioural phase model queues expected
// (voice, saw) pairs per tick; a monitor queues accepted samples; each test task compares.
module tb_osc_voice_scheduler;

    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        smp_tick = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_voice = '0;
    logic [23:0] cfg_increment = '0;
    logic        cfg_enable = 1'b0;
    logic        osc_valid;
    logic        osc_ready = 1'b1;
    logic [1:0]  osc_voice;
    logic [15:0] osc_saw;
    logic        busy;
    logic        sample_overrun;

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [23:0] ph_m  [NV];
    logic [23:0] inc_m [NV];
    logic        en_m  [NV];
    logic [17:0] exp_q [$];
    logic [17:0] obs_q [$];

    always #5 clk = ~clk;

    osc_voice_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .smp_tick       (smp_tick),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_voice      (cfg_voice),
        .cfg_increment  (cfg_increment),
        .cfg_enable     (cfg_enable),
        .osc_valid      (osc_valid),
        .osc_ready      (osc_ready),
        .osc_voice      (osc_voice),
        .osc_saw        (osc_saw),
        .busy           (busy),
        .sample_overrun (sample_overrun)
    );

    // Inputs change 1 time unit after posedge, so the negedge view equals the next edge's view.
    always @(negedge clk) begin
        if (!rst && osc_valid && osc_ready) obs_q.push_back({osc_voice, osc_saw});
    end

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            ph_m[v] = '0; inc_m[v] = '0; en_m[v] = 1'b0;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [23:0] inc, input logic en);
        cfg_valid = 1'b1; cfg_voice = v; cfg_increment = inc; cfg_enable = en;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        inc_m[v] = inc; en_m[v] = en;
    endtask

    task automatic tick();
        logic [15:0] saw;
        for (int v = 0; v < NV; v++) begin
            if (en_m[v]) begin
                ph_m[v] = ph_m[v] + inc_m[v];
                saw = ph_m[v][23:8] ^ 16'h8000;
            end else begin
                ph_m[v] = '0;
                saw = '0;
            end
            exp_q.push_back({2'(v), saw});
        end
        smp_tick = 1'b1;
        @(posedge clk); #1;
        smp_tick = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [17:0] e, o;
        bit ok;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_cnt++; if (osc_valid !== 1'b0) $display("FAIL reset_osc_valid: got %b want 0", osc_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (sample_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", sample_overrun); else pass_cnt++;
        chk_cnt++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); else pass_cnt++;
        chk_cnt++; if ({osc_voice, osc_saw} !== 18'h0) $display("FAIL reset_outputs: got %h want 0", {osc_voice, osc_saw}); else pass_cnt++;
        @(posedge clk); #1;
        tick();
        wait_idle(ok);
        chk_cnt++; if (!ok) $display("FAIL reset_frame_timeout: busy still 1, want 0"); else pass_cnt++;
        chk_cnt++; if (obs_q.size() != 4) $display("FAIL reset_sample_count: got %0d want 4", obs_q.size()); else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL reset_sample: got v%0d saw %h want v%0d saw %h", o[17:16], o[15:0], e[17:16], e[15:0]);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_single_voice();
        logic [17:0] e, o;
        int n, first, bhi;
        cfg_write(2'd0, 24'h010000, 1'b1);
        tick();
        n = 1; first = 0; bhi = busy ? 1 : 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (first == 0 && osc_valid) first = n;
            if (!busy) break;
            bhi++;
        end
        chk_cnt++; if (first != 2) $display("FAIL single_latency: first valid %0d cycles after tick, want 2", first); else pass_cnt++;
        chk_cnt++; if (bhi != 2 * NV) $display("FAIL single_busy_len: busy %0d cycles, want %0d", bhi, 2 * NV); else pass_cnt++;
        chk_cnt++; if (obs_q.size() != 4) $display("FAIL single_sample_count: got %0d want 4", obs_q.size()); else pass_cnt++;
        chk_cnt++; if (obs_q.size() > 0 && obs_q[0] !== {2'd0, 16'h8100}) $display("FAIL single_voice0: got %h want %h", obs_q[0], {2'd0, 16'h8100}); else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL single_sample: got v%0d saw %h want v%0d saw %h", o[17:16], o[15:0], e[17:16], e[15:0]);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wrap();
        logic [17:0] e, o;
        logic [15:0] wrap_exp [3];
        int k;
        bit ok;
        wrap_exp[0] = 16'h0000; wrap_exp[1] = 16'h8000; wrap_exp[2] = 16'h0000;
        cfg_write(2'd2, 24'h800000, 1'b1);
        for (int t = 0; t < 3; t++) begin
            tick();
            wait_idle(ok);
            chk_cnt++; if (!ok) $display("FAIL wrap_frame_timeout: frame %0d never finished", t); else pass_cnt++;
        end
        chk_cnt++; if (obs_q.size() != 12) $display("FAIL wrap_sample_count: got %0d want 12", obs_q.size()); else pass_cnt++;
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL wrap_sample: got v%0d saw %h want v%0d saw %h", o[17:16], o[15:0], e[17:16], e[15:0]);
            else pass_cnt++;
            if (o[17:16] == 2'd2 && k < 3) begin
                chk_cnt++;
                if (o[15:0] !== wrap_exp[k]) $display("FAIL wrap_voice2_%0d: got %h want %h", k, o[15:0], wrap_exp[k]);
                else pass_cnt++;
                k++;
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [17:0] e, o;
        logic [15:0] want_saw;
        bit found, ok;
        cfg_write(2'd1, 24'h123456, 1'b1);
        tick();
        want_saw = exp_q[1][15:0];
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (osc_valid && osc_voice == 2'd0) found = 1'b1;
        end
        chk_cnt++; if (!found) $display("FAIL bp_voice0_timeout: voice 0 never valid"); else pass_cnt++;
        @(posedge clk); #1;
        osc_ready = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_cnt++;
            if (osc_valid !== 1'b1 || osc_voice !== 2'd1 || osc_saw !== want_saw || cfg_ready !== 1'b0)
                $display("FAIL bp_stall_%0d: got valid %b voice %0d saw %h cfg_ready %b want 1 1 %h 0",
                         c, osc_valid, osc_voice, osc_saw, cfg_ready, want_saw);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        osc_ready = 1'b1;
        wait_idle(ok);
        chk_cnt++; if (!ok) $display("FAIL bp_frame_timeout: frame never finished"); else pass_cnt++;
        chk_cnt++; if (obs_q.size() != 4) $display("FAIL bp_sample_count: got %0d want 4", obs_q.size()); else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL bp_sample: got v%0d saw %h want v%0d saw %h", o[17:16], o[15:0], e[17:16], e[15:0]);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_overrun();
        logic [17:0] e, o;
        int ov;
        tick();
        ov = 0;
        for (int i = 0; i < 40; i++) begin
            smp_tick = (i == 2);
            @(negedge clk);
            if (sample_overrun) ov++;
            @(posedge clk); #1;
        end
        smp_tick = 1'b0;
        chk_cnt++; if (ov != 1) $display("FAIL overrun_pulse: high %0d cycles, want 1", ov); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL overrun_second_frame: busy %b, want 0", busy); else pass_cnt++;
        chk_cnt++; if (obs_q.size() != 4) $display("FAIL overrun_sample_count: got %0d want 4", obs_q.size()); else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL overrun_sample: got v%0d saw %h want v%0d saw %h", o[17:16], o[15:0], e[17:16], e[15:0]);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [17:0] e, o;
        bit found, ok;
        cfg_write(2'd3, 24'h0F0F0F, 1'b1);
        tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (osc_valid && osc_voice == 2'd0) found = 1'b1;
        end
        chk_cnt++; if (!found) $display("FAIL rstmid_voice0_timeout: voice 0 never valid"); else pass_cnt++;
        @(posedge clk); #1;
        osc_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        osc_ready = 1'b1;
        model_reset();
        @(negedge clk);
        chk_cnt++; if (osc_valid !== 1'b0) $display("FAIL rstmid_osc_valid: got %b want 0", osc_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (cfg_ready !== 1'b1) $display("FAIL rstmid_cfg_ready: got %b want 1", cfg_ready); else pass_cnt++;
        @(posedge clk); #1;
        cfg_write(2'd0, 24'h010000, 1'b1);
        tick();
        wait_idle(ok);
        chk_cnt++; if (!ok) $display("FAIL rstmid_frame_timeout: frame never finished"); else pass_cnt++;
        chk_cnt++; if (obs_q.size() != 4) $display("FAIL rstmid_sample_count: got %0d want 4", obs_q.size()); else pass_cnt++;
        chk_cnt++; if (obs_q.size() > 0 && obs_q[0] !== {2'd0, 16'h8100}) $display("FAIL rstmid_voice0: got %h want %h", obs_q[0], {2'd0, 16'h8100}); else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            chk_cnt++;
            if (o !== e) $display("FAIL rstmid_sample: got v%0d saw %h want v%0d saw %h", o[17:16], o[15:0], e[17:16], e[15:0]);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_voice();
        test_wrap();
        test_backpressure();
        test_overrun();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
